// File: rtl/evr_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : evr_pulse_pkg
// Purpose  : Shared types and constants for the EVR pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
package evr_pulse_pkg;

  // Per-channel sequencer states
  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_DELAY  = 2'd1,
    CH_ACTIVE = 2'd2
  } ch_state_e;

  // Event code 0x00 is the null code and never triggers anything
  localparam logic [7:0] EVCODE_NULL = 8'h00;

  // Upper bound on the number of pulse channels supported by the block
  localparam int CHANNEL_COUNT_MAX = 16;

endpackage : evr_pulse_pkg
`default_nettype wire

// File: rtl/evr_pulse_channel.sv
`default_nettype none
// ============================================================================
// Module   : evr_pulse_channel
// Purpose  : One trigger channel: config registers, IDLE/DELAY/ACTIVE
//            sequencer and shared delay/width down-counter.
//            Macro EVR_PULSE_RETRIGGER_EN: when defined, a trigger while the
//            channel is busy restarts it; otherwise such triggers are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module evr_pulse_channel
  import evr_pulse_pkg::*;
#(
  parameter int DELAY_WIDTH = 24,
  parameter int WIDTH_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_trig,
  input  logic                   i_cfg_we,
  input  logic [DELAY_WIDTH-1:0] i_cfg_delay,
  input  logic [WIDTH_WIDTH-1:0] i_cfg_width,
  output logic                   o_pulse,
  output logic                   o_busy
);

  localparam int CNT_W = (DELAY_WIDTH > WIDTH_WIDTH) ? DELAY_WIDTH : WIDTH_WIDTH;

`ifdef EVR_PULSE_RETRIGGER_EN
  localparam logic RETRIGGER = 1'b1;
`else
  localparam logic RETRIGGER = 1'b0;
`endif

  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH_WIDTH-1:0] width_lat_q, width_lat_d;
  logic [DELAY_WIDTH-1:0] cfg_delay_q, cfg_delay_d;
  logic [WIDTH_WIDTH-1:0] cfg_width_q, cfg_width_d;
  logic                   pulse_q, pulse_d;
  logic                   busy_q, busy_d;
  logic                   w_start;

  // Config registers: a write only changes what the next trigger latches
  always_comb begin
    cfg_delay_d = cfg_delay_q;
    cfg_width_d = cfg_width_q;
    if (i_cfg_we) begin
      cfg_delay_d = i_cfg_delay;
      cfg_width_d = i_cfg_width;
    end
  end

  // Sequencer next-state: counter never reaches 0 inside DELAY/ACTIVE, so no wrap
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    width_lat_d = width_lat_q;
    w_start     = i_trig && (cfg_width_q != '0) &&
                  ((state_q == CH_IDLE) || RETRIGGER);

    case (state_q)
      CH_IDLE: begin
        cnt_d = '0;
      end
      CH_DELAY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = CH_ACTIVE;
          cnt_d   = CNT_W'(width_lat_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CH_ACTIVE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A start (from IDLE, or a restart when retriggering) overrides the above
    if (w_start) begin
      width_lat_d = cfg_width_q;
      if (cfg_delay_q == '0) begin
        state_d = CH_ACTIVE;
        cnt_d   = CNT_W'(cfg_width_q);
      end else begin
        state_d = CH_DELAY;
        cnt_d   = CNT_W'(cfg_delay_q);
      end
    end

    pulse_d = (state_d == CH_ACTIVE);
    busy_d  = (state_d != CH_IDLE);
  end

  // State, counter, config and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CH_IDLE;
      cnt_q       <= '0;
      width_lat_q <= '0;
      cfg_delay_q <= '0;
      cfg_width_q <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_lat_q <= width_lat_d;
      cfg_delay_q <= cfg_delay_d;
      cfg_width_q <= cfg_width_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
    end
  end

  assign o_pulse = pulse_q;
  assign o_busy  = busy_q;

endmodule : evr_pulse_channel
`default_nettype wire

// File: rtl/evr_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module   : evr_pulse_generator
// Purpose  : EVR event decoder with 256-entry code->channel-mask table and
//            CHANNEL_COUNT delay/width pulse channels.
//            Macro EVR_PULSE_RETRIGGER_EN (in evr_pulse_channel): enables
//            restart of busy channels on a new trigger.
// Revision : 1.0 - initial release
// ============================================================================
module evr_pulse_generator
  import evr_pulse_pkg::*;
#(
  parameter int CHANNEL_COUNT = 4,
  parameter int DELAY_WIDTH   = 24,
  parameter int WIDTH_WIDTH   = 16,
  localparam int CH_SEL_W     = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                     evrRxClk,
  input  logic                     evrRxReset,
  input  logic [15:0]              evrRxWord,
  input  logic [1:0]               evrCharIsK,
  input  logic                     tableWriteEnable,
  input  logic [7:0]               tableAddress,
  input  logic [CHANNEL_COUNT-1:0] tableData,
  input  logic                     cfgWriteEnable,
  input  logic [CH_SEL_W-1:0]      cfgChannel,
  input  logic [DELAY_WIDTH-1:0]   cfgDelay,
  input  logic [WIDTH_WIDTH-1:0]   cfgWidth,
  output logic [7:0]               distributedDataBus,
  output logic [CHANNEL_COUNT-1:0] pulse,
  output logic [CHANNEL_COUNT-1:0] channelBusy
);

  // Contents rely on the target's all-zero memory power-up; reset leaves them alone
  logic [CHANNEL_COUNT-1:0] table_mem_q [256];

  logic [7:0]               code_q, code_d;
  logic [7:0]               dbus_q, dbus_d;
  logic                     valid0_q, valid0_d;
  logic                     valid1_q, valid1_d;
  logic [CHANNEL_COUNT-1:0] mask_q, mask_d;
  logic [CHANNEL_COUNT-1:0] trig_q, trig_d;

  // Table write port; a same-edge read of the same entry sees the old mask
  always_ff @(posedge evrRxClk) begin
    if (tableWriteEnable) begin
      table_mem_q[tableAddress] <= tableData;
    end
  end

  // Pipeline: stage 0 capture/validate, stage 1 table read, then gated trigger
  always_comb begin
    code_d   = evrRxWord[7:0];
    dbus_d   = evrRxWord[15:8];
    valid0_d = !evrCharIsK[0] && (evrRxWord[7:0] != EVCODE_NULL);
    valid1_d = valid0_q;
    mask_d   = table_mem_q[code_q];
    trig_d   = valid1_q ? mask_q : '0;
  end

  // Pipeline registers; reset drops any event in flight
  always_ff @(posedge evrRxClk) begin
    if (evrRxReset) begin
      code_q   <= '0;
      dbus_q   <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      mask_q   <= '0;
      trig_q   <= '0;
    end else begin
      code_q   <= code_d;
      dbus_q   <= dbus_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      mask_q   <= mask_d;
      trig_q   <= trig_d;
    end
  end

  assign distributedDataBus = dbus_q;

  for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_channel
    logic w_cfg_we;
    // Indices beyond CHANNEL_COUNT match no channel, so such writes vanish
    assign w_cfg_we = cfgWriteEnable && (cfgChannel == CH_SEL_W'(gi));

    evr_pulse_channel #(
      .DELAY_WIDTH (DELAY_WIDTH),
      .WIDTH_WIDTH (WIDTH_WIDTH)
    ) u_channel (
      .clk         (evrRxClk),
      .rst         (evrRxReset),
      .i_trig      (trig_q[gi]),
      .i_cfg_we    (w_cfg_we),
      .i_cfg_delay (cfgDelay),
      .i_cfg_width (cfgWidth),
      .o_pulse     (pulse[gi]),
      .o_busy      (channelBusy[gi])
    );
  end

endmodule : evr_pulse_generator
`default_nettype wire
